// File: rtl/fir_mac_sequencer_if.sv
// Bundle between the FIR sample source / coefficient SRAM / MAC and the tap sequencer.
// master: environment side (drives samples and SRAM read data).
// slave: sequencer side (drives SRAM address/select and the MAC tap stream).
interface fir_mac_sequencer_if #(
  parameter int COEFF_W = 16,
  parameter int DATA_W  = 3,
  parameter int ADDR_W  = 4
);
  logic               iEnSample;
  logic [DATA_W-1:0]  iFirIn;
  logic               oCsn;
  logic [ADDR_W-1:0]  oRdAddr;
  logic [COEFF_W-1:0] iRdDt;
  logic [COEFF_W-1:0] oCoeff;
  logic [DATA_W-1:0]  oFIRin;
  logic [ADDR_W-1:0]  oInSel;
  logic               oEnDelay;
  logic               oBusy;
  logic               oValid;
  logic               oOverrun;

  modport master (
    output iEnSample, iFirIn, iRdDt,
    input  oCsn, oRdAddr, oCoeff, oFIRin, oInSel, oEnDelay, oBusy, oValid, oOverrun
  );

  modport slave (
    input  iEnSample, iFirIn, iRdDt,
    output oCsn, oRdAddr, oCoeff, oFIRin, oInSel, oEnDelay, oBusy, oValid, oOverrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Purpose: FIR tap sequencer; shifts the sample delay line, walks the coefficient SRAM, feeds the MAC.
// Latency: sample strobe at T0 -> SRAM address 0 at T1 -> tap 0 at T2 -> oValid at T2+TAPS-1+MAC_LAT.
// Backpressure: none; a sample arriving while busy is dropped and flags sticky oOverrun.
// Optional: define SEQ_PENDING_BUF_EN to hold one early sample and chain it without an IDLE cycle.
module fir_mac_sequencer #(
  parameter int TAPS    = 10,
  parameter int COEFF_W = 16,
  parameter int DATA_W  = 3,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 2
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  fir_mac_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

  localparam int                 FLUSH_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0]  LAST_TAP   = ADDR_W'(TAPS - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(MAC_LAT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   tapCnt;
  logic [FLUSH_W-1:0]  flushCnt;
  logic [DATA_W-1:0]   dLine [TAPS];

  logic                csn;
  logic [ADDR_W-1:0]   rdAddr;
  logic [DATA_W-1:0]   firOut;
  logic [ADDR_W-1:0]   inSel;
  logic                enDelay;
  logic                busy;
  logic                valid;
  logic                overrun;

  logic                lastFlush;
  logic                doShift;
  logic [DATA_W-1:0]   shiftDat;

`ifdef SEQ_PENDING_BUF_EN
  logic                pendFull;
  logic [DATA_W-1:0]   pendDat;
`endif

  assign lastFlush = (state == FLUSH) && (flushCnt == LAST_FLUSH);

  // Pick whether a sample enters the delay line this cycle, and which one.
  always_comb begin
    doShift  = 1'b0;
    shiftDat = bus.iFirIn;
    if ((state == IDLE) && bus.iEnSample) begin
      doShift = 1'b1;
    end
`ifdef SEQ_PENDING_BUF_EN
    // Chaining straight from FLUSH: a buffered sample wins over a fresh one.
    if (lastFlush && pendFull) begin
      doShift  = 1'b1;
      shiftDat = pendDat;
    end else if (lastFlush && bus.iEnSample) begin
      doShift = 1'b1;
    end
`endif
  end

  // Sequencer FSM, delay line and all registered MAC/SRAM-facing outputs.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      tapCnt   <= '0;
      flushCnt <= '0;
      for (int k = 0; k < TAPS; k++) dLine[k] <= '0;
      csn      <= 1'b1;
      rdAddr   <= '0;
      firOut   <= '0;
      inSel    <= '0;
      enDelay  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (doShift) begin
        dLine[0] <= shiftDat;
        for (int k = 1; k < TAPS; k++) dLine[k] <= dLine[k-1];
      end

      case (state)
        IDLE: begin
          if (doShift) begin
            state  <= READ;
            tapCnt <= '0;
            csn    <= 1'b0;
            rdAddr <= '0;
            busy   <= 1'b1;
          end
        end
        READ: begin
          // Tap k is presented one cycle after its address, lining up with iRdDt.
          firOut  <= dLine[tapCnt];
          inSel   <= tapCnt;
          enDelay <= (tapCnt == '0);
          if (tapCnt == LAST_TAP) begin
            csn   <= 1'b1;
            state <= DRAIN;
          end else begin
            tapCnt <= tapCnt + 1'b1;
            rdAddr <= tapCnt + 1'b1;
          end
        end
        DRAIN: begin
          enDelay  <= 1'b0;
          flushCnt <= '0;
          valid    <= (MAC_LAT == 1);
          state    <= FLUSH;
        end
        FLUSH: begin
          if (lastFlush) begin
            valid <= 1'b0;
            if (doShift) begin
              state  <= READ;
              tapCnt <= '0;
              csn    <= 1'b0;
              rdAddr <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            flushCnt <= flushCnt + 1'b1;
            valid    <= ((flushCnt + 1'b1) == LAST_FLUSH);
          end
        end
        default: state <= IDLE;
      endcase

`ifdef SEQ_PENDING_BUF_EN
      if (bus.iEnSample && (state != IDLE) && pendFull) overrun <= 1'b1;
`else
      if (bus.iEnSample && (state != IDLE)) overrun <= 1'b1;
`endif
    end
  end

`ifdef SEQ_PENDING_BUF_EN
  // One-entry holding slot for a sample that arrives mid-sequence.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      pendFull <= 1'b0;
      pendDat  <= '0;
    end else if (lastFlush && pendFull) begin
      pendFull <= 1'b0;
    end else if (bus.iEnSample && (state != IDLE) && !pendFull && !lastFlush) begin
      pendFull <= 1'b1;
      pendDat  <= bus.iFirIn;
    end
  end
`endif

  assign bus.oCsn     = csn;
  assign bus.oRdAddr  = rdAddr;
  assign bus.oCoeff   = bus.iRdDt;
  assign bus.oFIRin   = firOut;
  assign bus.oInSel   = inSel;
  assign bus.oEnDelay = enDelay;
  assign bus.oBusy    = busy;
  assign bus.oValid   = valid;
  assign bus.oOverrun = overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed scenarios plus random sample strobes,
// each cycle compared against a timeline model (outputs derived from cycles since acceptance).
module tb_fir_mac_sequencer;
  localparam int TAPS    = 10;
  localparam int COEFF_W = 16;
  localparam int DATA_W  = 3;
  localparam int ADDR_W  = 4;
  localparam int MAC_LAT = 2;
  localparam int LASTK   = TAPS + 1 + MAC_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.COEFF_W(COEFF_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fir_mac_sequencer #(
    .TAPS(TAPS), .COEFF_W(COEFF_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .iClk_12M (clk),
    .iRst     (rst),
    .bus      (bus)
  );

  // Coefficient SRAM: one-cycle read latency, reads only while selected.
  logic [COEFF_W-1:0] mem [16];
  initial bus.iRdDt = '0;
  always @(posedge clk) if (!bus.oCsn) bus.iRdDt <= mem[bus.oRdAddr];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  int   cyc = 0;
  int   t0 = 0;
  bit   seqOn = 0;
  int   dl [TAPS];
  bit   ovr = 0;
  bit   pendFull = 0;
  int   pendDat = 0;
  int   hRdAddr = 0;
  int   hInSel = 0;
  int   hFir = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expV);
    nChecks++;
    if (obs !== expV) begin
      nFails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, expV);
    end
  endtask

  task automatic acceptSample(input int v);
    for (int i = TAPS - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = v;
    t0    = cyc;
    seqOn = 1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < TAPS; i++) dl[i] = 0;
    seqOn = 0; ovr = 0; pendFull = 0; pendDat = 0;
    hRdAddr = 0; hInSel = 0; hFir = 0;
  endtask

  // Called at posedge+1: asserts reset asynchronously, checks outputs before the next edge.
  task automatic applyReset();
    bus.iEnSample = 1'b0;
    bus.iFirIn    = '0;
    rst = 1'b1;
    #2;
    checkVal("rst_csn",     bus.oCsn,     1);
    checkVal("rst_rdaddr",  bus.oRdAddr,  0);
    checkVal("rst_firin",   bus.oFIRin,   0);
    checkVal("rst_insel",   bus.oInSel,   0);
    checkVal("rst_endelay", bus.oEnDelay, 0);
    checkVal("rst_busy",    bus.oBusy,    0);
    checkVal("rst_valid",   bus.oValid,   0);
    checkVal("rst_overrun", bus.oOverrun, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, advance the model.
  task automatic step(input bit en, input int smp);
    int k;
    bit idle, present, expCsn, expBusy, expValid, expEnD;
    bus.iEnSample = en;
    bus.iFirIn    = DATA_W'(smp);
    k        = seqOn ? (cyc - t0) : LASTK + 1;
    idle     = !seqOn || (k > LASTK);
    expCsn   = !(seqOn && k >= 1 && k <= TAPS);
    if (!expCsn) hRdAddr = k - 1;
    present  = seqOn && k >= 2 && k <= TAPS + 1;
    if (present) begin
      hInSel = k - 2;
      hFir   = dl[k-2];
    end
    expEnD   = seqOn && (k == 2);
    expBusy  = seqOn && k >= 1 && k <= LASTK;
    expValid = seqOn && (k == LASTK);

    @(negedge clk);
    checkVal("csn",     bus.oCsn,     expCsn);
    checkVal("rdaddr",  bus.oRdAddr,  hRdAddr);
    checkVal("insel",   bus.oInSel,   hInSel);
    checkVal("firin",   bus.oFIRin,   hFir);
    checkVal("endelay", bus.oEnDelay, expEnD);
    checkVal("busy",    bus.oBusy,    expBusy);
    checkVal("valid",   bus.oValid,   expValid);
    checkVal("overrun", bus.oOverrun, ovr);
    if (present) checkVal("coeff", bus.oCoeff, mem[k-2]);

`ifdef SEQ_PENDING_BUF_EN
    if (seqOn && k == LASTK) begin
      if (pendFull) begin
        acceptSample(pendDat);
        pendFull = 0;
        if (en) ovr = 1;
      end else if (en) begin
        acceptSample(smp);
      end
    end else if (en && idle) begin
      acceptSample(smp);
    end else if (en) begin
      if (pendFull) ovr = 1;
      else begin
        pendFull = 1;
        pendDat  = smp;
      end
    end
`else
    if (en && idle) acceptSample(smp);
    else if (en) ovr = 1;
`endif

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    bus.iEnSample = 1'b0;
    bus.iFirIn    = '0;
    for (int i = 0; i < 16; i++) mem[i] = COEFF_W'(i + 1);
    modelReset();
    @(posedge clk);
    #1;
    applyReset();
    runIdle(2);

    // Single sample through coefficients 1..10
    step(1, 3);
    runIdle(16);

    // Delay line ordering from a clean line: 1, 2, 3
    applyReset();
    step(1, 1); runIdle(14);
    step(1, 2); runIdle(14);
    step(1, 3); runIdle(16);

    // Earliest legal follow-on sample (T14)
    step(1, 6); runIdle(13);
    step(1, 7); runIdle(16);

    // Reset in the middle of READ (T5), then a fresh sequence
    step(1, 4); runIdle(4);
    applyReset();
    runIdle(2);
    step(1, 5); runIdle(16);

    // Samples at T6 and in the oValid cycle T13
    step(1, 2); runIdle(5);
    step(1, 7); runIdle(6);
    step(1, 1); runIdle(16);

    // Samples at T6 and T8
    applyReset();
    step(1, 3); runIdle(5);
    step(1, 4); runIdle(1);
    step(1, 5); runIdle(30);

    // Random strobes and coefficients
    for (int i = 0; i < 16; i++) mem[i] = COEFF_W'($urandom);
    applyReset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 11) == 0), int'($urandom_range(0, 7)));
    end
    runIdle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Tap sequencer that drives the MAC datapath (16x3 multiplier plus accumulator) of the FIR filter.
- On each new 3-bit input sample it shifts a TAPS-deep sample delay line.
- It walks the coefficient SP-SRAM one tap per cycle and presents coefficient, delayed sample, tap select and accumulator-restart strobe to the MAC.
- It flags when the MAC result is valid.
- It sits between the top-level sample/strobe source and the MAC top, and owns the SRAM read port.

Parameters:
TAPS, 10, number of filter taps (1..16)
COEFF_W, 16, coefficient width (SRAM read data)
DATA_W, 3, input sample width
ADDR_W, 4, SRAM address / tap-select width
MAC_LAT, 2, cycles from the last tap presented to the MAC until its output is valid

Ports:
iClk_12M  input  1  clock, rising edge
iRst  input  1  reset, asynchronous, active-high
iEnSample  input  1  one-cycle strobe: new sample on iFirIn
iFirIn  input  DATA_W  input sample
oCsn  output  1  SRAM chip select, active low (read only)
oRdAddr  output  ADDR_W  SRAM read address
iRdDt  input  COEFF_W  SRAM read data, valid 1 cycle after address
oCoeff  output  COEFF_W  coefficient to MAC (iRdDt pass-through)
oFIRin  output  DATA_W  delayed sample for current tap
oInSel  output  ADDR_W  tap index for current tap
oEnDelay  output  1  accumulator restart strobe, high with tap 0
oBusy  output  1  sequence in progress
oValid  output  1  one-cycle pulse: MAC output valid this cycle
oOverrun  output  1  sticky: a sample was dropped

Behaviour:
- Reset (asynchronous, any state, mid-sequence included):
  - State = IDLE; delay line all zero; tap counter 0.
  - oCsn=1, oRdAddr=0, oFIRin=0, oInSel=0, oEnDelay=0, oBusy=0, oValid=0, oOverrun=0.
  - oCoeff follows iRdDt at all times.
  - After reset release the first tap sequence restarts from tap 0; no partial result is ever flagged valid.
- FSM states IDLE, READ, DRAIN, FLUSH:
  - IDLE: when iEnSample=1 (edge T0), the delay line shifts (d[0]<=iFirIn, d[k]<=d[k-1]) and the state goes to READ.
  - READ: for cycle T1+k, k=0..TAPS-1, drive oCsn=0 and oRdAddr=k. After k=TAPS-1 go to DRAIN.
  - DRAIN: one cycle covering SRAM read latency. oCsn=1, oRdAddr holds its last value.
  - Tap presentation: at cycle T2+k, oFIRin=d[k] and oInSel=k (both registered, aligned to iRdDt for address k). oEnDelay=1 only at T2 (k=0). oFIRin/oInSel hold the last tap value when no tap is presented.
  - FLUSH: MAC_LAT cycles. oValid=1 in the final FLUSH cycle, i.e. cycle T2+TAPS-1+MAC_LAT (T13 for defaults); the state then returns to IDLE.
- oBusy = 1 from T1 through the oValid cycle inclusive. A new sample is accepted in the cycle after oValid at the earliest.
- The delay line is frozen during a sequence. Taps beyond TAPS are never addressed.
- iEnSample while state != IDLE: the sample is dropped, the delay line is unchanged, and oOverrun is set. oOverrun is cleared only by iRst.
- iEnSample in the same cycle that oValid is high is still an overrun: the state machine is not yet in IDLE.
- TAPS=1: the READ phase is one cycle, and oEnDelay and the last tap coincide.

Optional Feature:
SEQ_PENDING_BUF_EN
- Defined:
  - A one-entry pending buffer captures iFirIn on iEnSample while busy.
  - On leaving FLUSH with the buffer full, the FSM skips IDLE. It shifts the pending sample into the delay line in that same cycle and enters READ on the next edge.
  - oBusy stays high throughout.
  - oOverrun is set only if a sample arrives while the buffer is already full; that newest sample is dropped and the buffered one is kept.
- Undefined: no buffer; every sample arriving while busy is dropped and sets oOverrun.

Test Plan:
- Reset check: assert iRst mid-READ (at T5) -> all outputs return to their reset values immediately, asynchronously. After release, iEnSample with iFirIn=3'b101 -> d[0]=5, other taps 0, full sequence restarts from oRdAddr=0.
- Single sample: SRAM holds coeff[k]=k+1, iFirIn=3 at T0 -> oRdAddr 0..9 on T1..T10; oInSel 0..9 and oCoeff 1..10 on T2..T11; oFIRin=3 at T2 and 0 after; oEnDelay high only at T2; oValid only at T13.
- Delay line: feed samples 1,2,3 each with a full sequence between -> third sequence presents oFIRin 3,2,1,0,... for taps 0..9.
- Overrun: iEnSample at T6 and at T13 (oValid cycle) -> both dropped, delay line unchanged, oOverrun=1 and stays 1.
- Back-to-back limit: iEnSample at T14 -> accepted, new sequence with oRdAddr=0 at T15, oOverrun stays 0.
- With SEQ_PENDING_BUF_EN: samples at T6 and T8 -> T6 sample processed next with no IDLE cycle and oBusy continuously high; T8 sample dropped and oOverrun=1.
